// File: rtl/fifo_wptr.sv
// Write-side pointer, Gray publish, read-pointer sync and flags
// for the async FIFO.
module fifo_wptr #(
  parameter int addr_width = 4,
  parameter int af_margin  = 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [addr_width-1:0] rptr_g,
  output logic                  wclken,
  output logic [addr_width-2:0] waddress,
  output logic [addr_width-1:0] wptr_g,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [addr_width-1:0] wlevel,
  output logic                  woverflow
);

  localparam int MSB   = addr_width - 1;
  localparam int DEPTH = 1 << (addr_width - 1);
  localparam logic [MSB:0] AF_LVL = addr_width'(DEPTH - af_margin);
  localparam logic [MSB:0] ONE    = addr_width'(1);

  logic [MSB:0] wbin;
  logic [MSB:0] wbin_nxt;
  logic [MSB:0] rq1;
  logic [MSB:0] rq2;
  logic [MSB:0] rbin_s;

  function automatic logic [MSB:0] bin2gray(
    input logic [MSB:0] b
  );
    return b ^ (b >> 1);
  endfunction

  assign wbin_nxt = wbin + ONE;
  assign wclken   = winc & ~wfull;
  assign waddress = wbin[MSB-1:0];

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin      <= '0;
      wptr_g    <= '0;
      rq1       <= '0;
      rq2       <= '0;
      woverflow <= 1'b0;
    end else begin
      rq1 <= rptr_g;
      rq2 <= rq1;
      if (wclken) begin
        wbin   <= wbin_nxt;
        wptr_g <= bin2gray(wbin_nxt);
      end
      if (winc & wfull)
        woverflow <= 1'b1;
    end
  end

  // XOR-prefix from the MSB down
  always_comb begin
    rbin_s      = '0;
    rbin_s[MSB] = rq2[MSB];
    for (int i = MSB - 1; i >= 0; i--)
      rbin_s[i] = rbin_s[i+1] ^ rq2[i];
  end

  assign wlevel = wbin - rbin_s;
  assign wfull  = (wbin[MSB] != rbin_s[MSB]) &&
                  (wbin[MSB-1:0] == rbin_s[MSB-1:0]);
  assign walmost_full = (wlevel >= AF_LVL);

endmodule

// File: tb/tb_fifo_wptr.sv
// Directed bench for fifo_wptr: table vectors for fill, overflow
// and drain, hand sequences for reset, wrap and reset mid-fill.
module tb_fifo_wptr;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [3:0] rptr_g;
  logic       wclken;
  logic [2:0] waddress;
  logic [3:0] wptr_g;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  int total = 0;
  int bad   = 0;

  fifo_wptr #(.addr_width(4), .af_margin(1)) dut (
    .wclk(wclk),
    .wrst(wrst),
    .winc(winc),
    .rptr_g(rptr_g),
    .wclken(wclken),
    .waddress(waddress),
    .wptr_g(wptr_g),
    .wfull(wfull),
    .walmost_full(walmost_full),
    .wlevel(wlevel),
    .woverflow(woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [3:0] rptr;
    logic [2:0] pre_addr;
    logic       pre_en;
    logic [3:0] gptr;
    logic [3:0] lvl;
    logic       full;
    logic       af;
    logic       ovf;
  } vec_t;

  vec_t vt[16];

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] rp);
    wrst = 1'b1;
    winc = 1'b1;
    rptr_g = rp;
    step();
    step();
    wrst = 1'b0;
    winc = 1'b0;
    rptr_g = 4'b0000;
  endtask

  logic [3:0] wb;
  logic [3:0] prev_g;
  logic       saw_wrap;
  logic       any_full;

  initial begin
    wrst = 1'b1;
    winc = 1'b0;
    rptr_g = 4'b0000;

    // 1. reset with winc high and a nonzero read pointer
    do_reset(4'b0101);
    chk("rst_wptr_g", wptr_g, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_woverflow", woverflow, 0);
    chk("rst_waddress", waddress, 0);

    // 2-4. fill, overflow, drain sync
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{1'b1, 4'b0000, 3'(i), 1'b1, g(4'(i + 1)),
                4'(i + 1), (i == 7), (i >= 6), 1'b0};
    end
    for (int i = 8; i < 11; i++)
      vt[i] = '{1'b1, 4'b0000, 3'd0, 1'b0, 4'b1100,
                4'd8, 1'b1, 1'b1, 1'b1};
    vt[11] = '{1'b0, 4'b0000, 3'd0, 1'b0, 4'b1100,
               4'd8, 1'b1, 1'b1, 1'b1};
    vt[12] = '{1'b0, 4'b0010, 3'd0, 1'b0, 4'b1100,
               4'd8, 1'b1, 1'b1, 1'b1};
    vt[13] = '{1'b0, 4'b0010, 3'd0, 1'b0, 4'b1100,
               4'd5, 1'b0, 1'b0, 1'b1};
    vt[14] = '{1'b1, 4'b0010, 3'd0, 1'b1, 4'b1101,
               4'd6, 1'b0, 1'b0, 1'b1};
    vt[15] = '{1'b0, 4'b0010, 3'd1, 1'b0, 4'b1101,
               4'd6, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      winc = vt[i].winc;
      rptr_g = vt[i].rptr;
      #1;
      chk($sformatf("v%0d_waddress", i), waddress, vt[i].pre_addr);
      chk($sformatf("v%0d_wclken", i), wclken, vt[i].pre_en);
      step();
      chk($sformatf("v%0d_wptr_g", i), wptr_g, vt[i].gptr);
      chk($sformatf("v%0d_wlevel", i), wlevel, vt[i].lvl);
      chk($sformatf("v%0d_wfull", i), wfull, vt[i].full);
      chk($sformatf("v%0d_walmost_full", i), walmost_full, vt[i].af);
      chk($sformatf("v%0d_woverflow", i), woverflow, vt[i].ovf);
    end

    // 5. wrap with the read pointer trailing by two entries
    do_reset(4'b0000);
    winc = 1'b1;
    step();
    step();
    winc = 1'b0;
    step();
    step();
    chk("wrap_start_lvl", wlevel, 2);
    wb = 4'd2;
    saw_wrap = 1'b0;
    any_full = 1'b0;
    for (int k = 0; k < 20; k++) begin
      prev_g = wptr_g;
      winc = 1'b1;
      rptr_g = g(wb - 4'd1);
      step();
      wb = wb + 4'd1;
      winc = 1'b0;
      if (prev_g == 4'b1000 && wptr_g == 4'b0000)
        saw_wrap = 1'b1;
      if (wfull) any_full = 1'b1;
      chk($sformatf("wrap%0d_wptr_g", k), wptr_g, g(wb));
      step();
      if (wfull) any_full = 1'b1;
      step();
      if (wfull) any_full = 1'b1;
      chk($sformatf("wrap%0d_wlevel", k), wlevel, 2);
    end
    chk("wrap_seen_1000_0000", saw_wrap, 1);
    chk("wrap_never_full", any_full, 0);
    chk("wrap_waddress", waddress, 6);

    // 6. reset mid-fill coinciding with a write
    do_reset(4'b0000);
    winc = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("mid_wptr_g_pre", wptr_g, g(4'd5));
    rptr_g = 4'b0011;
    wrst = 1'b1;
    step();
    wrst = 1'b0;
    winc = 1'b0;
    chk("mid_wptr_g", wptr_g, 0);
    chk("mid_wlevel", wlevel, 0);
    chk("mid_waddress", waddress, 0);
    step();
    chk("mid_rq1_cleared", wlevel, 0);
    step();
    chk("mid_rq_follow", wlevel, 14);
    chk("mid_woverflow", woverflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
